// File: rtl/apb_master.sv
// apb_master: turns a valid/ready command stream into single APB transfers.
//
// Parameters
//   ADDR_W          address width (cmd_addr, paddr)
//   DATA_W          data width (cmd_wdata, pwdata, prdata, rsp_rdata); strobes are DATA_W/8
//   TIMEOUT_CYCLES  ACCESS cycles without pready before the transfer is aborted
//
// Optional feature
//   APB_MASTER_TIMEOUT_EN  when defined, an ACCESS phase that never sees pready is aborted
//                          after TIMEOUT_CYCLES cycles with rsp_err=1 and rsp_rdata=0.
//                          When undefined, ACCESS waits for pready indefinitely.
//
// Ports
//   pclk, rst                      clock (rising edge), synchronous active-low reset
//   cmd_valid/cmd_ready            command handshake; cmd_ready is high only in IDLE
//   cmd_write/addr/wdata/strb      command payload, captured on acceptance
//   rsp_valid/rsp_ready            response handshake; response held until consumed
//   rsp_rdata, rsp_err             read data (0 for writes/aborts), error status
//   psel/penable/pwrite/paddr/
//   pwdata/pstrb                   APB requester outputs (all registered)
//   pready/prdata/pslverr          APB completer inputs
//   busy                           high in SETUP or ACCESS
//
// Every output is a flop or a decode of the state register; no input reaches an
// output combinationally.

module apb_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic                pready,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pslverr,
  output logic                busy
);

  localparam int unsigned StrbW = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [StrbW-1:0]    pstrb_q, pstrb_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CntW-1:0] to_cnt_q, to_cnt_d;
`else
  // Parameter is only meaningful with the timeout feature compiled in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        // cmd_ready_q gates acceptance so the first cycle after reset release,
        // when cmd_ready is still low, never takes a command.
        if (cmd_valid && cmd_ready_q) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pstrb_d  = cmd_write ? cmd_strb : '0;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        state_d = StAccess;
`ifdef APB_MASTER_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      StAccess: begin
        if (pready) begin
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
          pwrite_d    = 1'b0;
          paddr_d     = '0;
          pwdata_d    = '0;
          pstrb_d     = '0;
          state_d     = StResp;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        // Abort when this wait cycle brings the count to TIMEOUT_CYCLES.
        else if (to_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          to_cnt_d    = to_cnt_q + 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          pwrite_d    = 1'b0;
          paddr_d     = '0;
          pwdata_d    = '0;
          pstrb_d     = '0;
          state_d     = StResp;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    cmd_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign psel      = (state_q == StSetup) || (state_q == StAccess);
  assign penable   = (state_q == StAccess);
  assign busy      = psel;
  assign rsp_valid = (state_q == StResp);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
